// File: rtl/lsu_wb.sv
// LSU writeback stage.
//
// Takes the memory read response for a load and aligns/extends it according
// to the load's size, byte offset and sign mode. It then drives the LSU lane's
// register-file write port. While a load response is outstanding the upstream
// LSU stages are held via stall_out. If no response arrives within
// TIMEOUT_CYCLES, the load is abandoned.
//
// State | Meaning
// ------+-----------------------------------------------------------------
// IDLE  | accepting a new op from the EX/WB register; immediate completion
// WAIT  | aligned load accepted, waiting for mem_rvalid (captured fields)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   is_load_in, zero_ext_in  op is a load / zero-extend (else sign-extend)
//   is_nop_in                slot carries a NOP
//   size_in                  00 byte, 01 half, 10 word, 11 illegal
//   rd_in, addr_lo_in        destination register, load byte offset
//   mem_rdata, mem_rvalid    memory read response
//   rf_we/rf_waddr/rf_wdata  registered register-file write port
//   stall_out                hold upstream LSU stages (combinational)
//   misaligned_err           one-cycle pulse: misaligned or illegal-size load
//   timeout_err              one-cycle pulse: load response never arrived

module lsu_wb #(
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              is_load_in,
    input  logic              zero_ext_in,
    input  logic              is_nop_in,
    input  logic [1:0]        size_in,
    input  logic [4:0]        rd_in,
    input  logic [1:0]        addr_lo_in,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              stall_out,
    output logic              misaligned_err,
    output logic              timeout_err
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [0:0]       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;

    logic [4:0] cap_rd;
    logic [1:0] cap_size;
    logic       cap_zext;
    logic [1:0] cap_off;

    logic live_load;
    logic misaligned;
    logic accept;
    logic do_write;
    logic expire;

    logic [4:0]        sel_rd;
    logic [1:0]        sel_size;
    logic              sel_zext;
    logic [1:0]        sel_off;
    logic [7:0]        ext_b;
    logic [15:0]       ext_h;
    logic [DATA_W-1:0] ext_data;

    assign live_load  = is_load_in && !is_nop_in;
    assign misaligned = (size_in == 2'b11) ||
                        (size_in == 2'b01 && addr_lo_in[0]) ||
                        (size_in == 2'b10 && addr_lo_in != 2'b00);
    assign accept     = (state == S_IDLE) && live_load && !misaligned;
    assign expire     = (state == S_WAIT) && !mem_rvalid && (cnt == CNT_LAST);
    assign do_write   = mem_rvalid && (accept || state == S_WAIT);

    // An immediate response in IDLE completes before the capture registers
    // load, so the write path reads the live fields in IDLE and the captured
    // fields in WAIT.
    always_comb begin
        sel_rd   = cap_rd;
        sel_size = cap_size;
        sel_zext = cap_zext;
        sel_off  = cap_off;
        if (state == S_IDLE) begin
            sel_rd   = rd_in;
            sel_size = size_in;
            sel_zext = zero_ext_in;
            sel_off  = addr_lo_in;
        end
    end

    always_comb begin
        ext_b    = mem_rdata[{sel_off, 3'b000} +: 8];
        ext_h    = mem_rdata[{sel_off[1], 4'b0000} +: 16];
        ext_data = mem_rdata;
        case (sel_size)
            2'b00:   ext_data = {{(DATA_W-8){!sel_zext && ext_b[7]}}, ext_b};
            2'b01:   ext_data = {{(DATA_W-16){!sel_zext && ext_h[15]}}, ext_h};
            default: ext_data = mem_rdata;
        endcase
    end

    always_comb begin
        if (rst) begin
            stall_out = 1'b0;
        end else if (state == S_WAIT) begin
            stall_out = !mem_rvalid;
        end else begin
            stall_out = accept && !mem_rvalid;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            S_IDLE: begin
                if (accept && !mem_rvalid) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (mem_rvalid || expire) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            cap_rd         <= '0;
            cap_size       <= '0;
            cap_zext       <= 1'b0;
            cap_off        <= '0;
            rf_we          <= 1'b0;
            rf_waddr       <= '0;
            rf_wdata       <= '0;
            misaligned_err <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            misaligned_err <= (state == S_IDLE) && live_load && misaligned;
            timeout_err    <= expire;
            if (accept) begin
                cap_rd   <= rd_in;
                cap_size <= size_in;
                cap_zext <= zero_ext_in;
                cap_off  <= addr_lo_in;
            end
            // A load to x0 finishes the handshake but leaves the port untouched.
            rf_we <= do_write && (sel_rd != 5'd0);
            if (do_write && sel_rd != 5'd0) begin
                rf_waddr <= sel_rd;
                rf_wdata <= ext_data;
            end
        end
    end

endmodule

// File: tb/tb_lsu_wb.sv
module tb_lsu_wb;

    localparam int TO = 16;

    logic        clk;
    logic        rst;
    logic        is_load_in, zero_ext_in, is_nop_in;
    logic [1:0]  size_in, addr_lo_in;
    logic [4:0]  rd_in;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall_out, misaligned_err, timeout_err;

    lsu_wb #(.DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .is_load_in(is_load_in), .zero_ext_in(zero_ext_in), .is_nop_in(is_nop_in),
        .size_in(size_in), .rd_in(rd_in), .addr_lo_in(addr_lo_in),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .stall_out(stall_out), .misaligned_err(misaligned_err), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ld, zx, nop;
        logic [1:0]  sz;
        logic [4:0]  rd;
        logic [1:0]  lo;
        logic [31:0] rdata;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        mis;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        mis;
        logic        tmo;
        string       tag;
    } exp_t;

    vec_t  vecs[12];
    exp_t  exp_q[$];
    int    total = 0;
    int    bad   = 0;
    logic [4:0]  held_waddr = '0;
    logic [31:0] held_wdata = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive(input logic ld, input logic zx, input logic nop, input logic [1:0] sz,
                         input logic [4:0] rd, input logic [1:0] lo, input logic [31:0] rdata,
                         input logic rv);
        is_load_in  = ld;
        zero_ext_in = zx;
        is_nop_in   = nop;
        size_in     = sz;
        rd_in       = rd;
        addr_lo_in  = lo;
        mem_rdata   = rdata;
        mem_rvalid  = rv;
        #2;
    endtask

    task automatic idle_in();
        drive(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'b00, 32'h0, 1'b0);
    endtask

    task automatic chk_stall(input logic req, input string tag);
        chk({tag, ".stall"}, {31'b0, stall_out}, {31'b0, req});
    endtask

    // Expectation is queued when the stimulus for the cycle is in place and
    // popped once the registered outputs for that cycle are visible.
    task automatic tick(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic mis, input logic tmo, input string tag);
        exp_t e;
        e = '{we: we, waddr: wa, wdata: wd, mis: mis, tmo: tmo, tag: tag};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (e.we) begin
            held_waddr = e.waddr;
            held_wdata = e.wdata;
        end
        chk({e.tag, ".we"},    {31'b0, rf_we},          {31'b0, e.we});
        chk({e.tag, ".waddr"}, {27'b0, rf_waddr},       {27'b0, held_waddr});
        chk({e.tag, ".wdata"}, rf_wdata,                held_wdata);
        chk({e.tag, ".mis"},   {31'b0, misaligned_err}, {31'b0, e.mis});
        chk({e.tag, ".tmo"},   {31'b0, timeout_err},    {31'b0, e.tmo});
    endtask

    initial begin
        //          ld    zx    nop   sz     rd     lo     rdata          we    waddr  wdata          mis
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'b00, 5'd5,  2'd3, 32'h8012_3456, 1'b1, 5'd5,  32'hFFFF_FF80, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 2'b00, 5'd6,  2'd1, 32'h8012_3456, 1'b1, 5'd6,  32'h0000_0034, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 2'b01, 5'd8,  2'd0, 32'h1234_8001, 1'b1, 5'd8,  32'hFFFF_8001, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 2'b01, 5'd10, 2'd2, 32'h7FFF_0000, 1'b1, 5'd10, 32'h0000_7FFF, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 2'b10, 5'd11, 2'd0, 32'hDEAD_BEEF, 1'b1, 5'd11, 32'hDEAD_BEEF, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 2'b10, 5'd12, 2'd1, 32'h1111_1111, 1'b0, 5'd0,  32'h0,         1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 2'b11, 5'd12, 2'd0, 32'h2222_2222, 1'b0, 5'd0,  32'h0,         1'b1};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 2'b01, 5'd12, 2'd1, 32'h3333_3333, 1'b0, 5'd0,  32'h0,         1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 2'b10, 5'd0,  2'd0, 32'h4444_4444, 1'b0, 5'd0,  32'h0,         1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 2'b10, 5'd14, 2'd0, 32'h5555_5555, 1'b0, 5'd0,  32'h0,         1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 2'b10, 5'd15, 2'd0, 32'h6666_6666, 1'b0, 5'd0,  32'h0,         1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 2'b00, 5'd31, 2'd2, 32'h00FF_0000, 1'b1, 5'd31, 32'h0000_00FF, 1'b0};

        rst = 1'b1;
        idle_in();
        tick(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, "reset0");
        drive(1'b1, 1'b0, 1'b0, 2'b10, 5'd3, 2'd0, 32'h0, 1'b0);
        chk_stall(1'b0, "reset_load");
        tick(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, "reset1");
        rst = 1'b0;
        idle_in();
        chk_stall(1'b0, "idle");
        tick(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, "idle");

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].ld, vecs[i].zx, vecs[i].nop, vecs[i].sz, vecs[i].rd,
                  vecs[i].lo, vecs[i].rdata, 1'b1);
            chk_stall(1'b0, $sformatf("vec%0d", i));
            tick(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].mis, 1'b0,
                 $sformatf("vec%0d", i));
        end
        idle_in();
        tick(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, "after_vecs");

        // Half load, response three cycles late; upstream junk must be ignored.
        drive(1'b1, 1'b1, 1'b0, 2'b01, 5'd7, 2'd2, 32'h0, 1'b0);
        chk_stall(1'b1, "half_w0");
        tick(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, "half_w0");
        for (int i = 1; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 2'b11, 5'd3, 2'd1, 32'h0, 1'b0);
            chk_stall(1'b1, $sformatf("half_w%0d", i));
            tick(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, $sformatf("half_w%0d", i));
        end
        drive(1'b1, 1'b0, 1'b0, 2'b11, 5'd3, 2'd1, 32'hBEEF_0000, 1'b1);
        chk_stall(1'b0, "half_rsp");
        tick(1'b1, 5'd7, 32'h0000_BEEF, 1'b0, 1'b0, "half_rsp");
        idle_in();
        tick(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, "half_after");

        // Timeout: no response at all.
        drive(1'b1, 1'b0, 1'b0, 2'b10, 5'd9, 2'd0, 32'h0, 1'b0);
        for (int i = 0; i < TO; i++) begin
            chk_stall(1'b1, $sformatf("to_c%0d", i));
            tick(1'b0, 5'd0, 32'h0, 1'b0, (i == TO - 1), $sformatf("to_c%0d", i));
            idle_in();
        end
        chk_stall(1'b0, "to_after");
        tick(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, "to_after");

        // Response on the last allowed cycle wins over expiry.
        drive(1'b1, 1'b0, 1'b0, 2'b10, 5'd9, 2'd0, 32'h0, 1'b0);
        for (int i = 0; i < TO - 1; i++) begin
            chk_stall(1'b1, $sformatf("late_c%0d", i));
            tick(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, $sformatf("late_c%0d", i));
            idle_in();
        end
        drive(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'd0, 32'hCAFE_F00D, 1'b1);
        chk_stall(1'b0, "late_rsp");
        tick(1'b1, 5'd9, 32'hCAFE_F00D, 1'b0, 1'b0, "late_rsp");
        idle_in();
        tick(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, "late_after");

        // Delayed load to x0: handshake completes, no write.
        drive(1'b1, 1'b0, 1'b0, 2'b10, 5'd0, 2'd0, 32'h0, 1'b0);
        chk_stall(1'b1, "x0_w");
        tick(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, "x0_w");
        drive(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'd0, 32'h7777_7777, 1'b1);
        chk_stall(1'b0, "x0_rsp");
        tick(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, "x0_rsp");
        idle_in();
        chk_stall(1'b0, "x0_after");
        tick(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, "x0_after");

        // Reset while waiting, then a stray response after release.
        drive(1'b1, 1'b0, 1'b0, 2'b10, 5'd12, 2'd0, 32'h0, 1'b0);
        tick(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, "rstw_0");
        idle_in();
        chk_stall(1'b1, "rstw_1");
        tick(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, "rstw_1");
        rst = 1'b1;
        #2;
        chk_stall(1'b0, "rstw_rst");
        held_waddr = '0;
        held_wdata = '0;
        tick(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, "rstw_rst");
        rst = 1'b0;
        idle_in();
        chk_stall(1'b0, "rstw_rel");
        tick(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, "rstw_rel");
        drive(1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 2'd0, 32'hAAAA_AAAA, 1'b1);
        chk_stall(1'b0, "rstw_stray");
        tick(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, "rstw_stray");
        drive(1'b1, 1'b0, 1'b0, 2'b10, 5'd13, 2'd0, 32'h1234_5678, 1'b1);
        chk_stall(1'b0, "rstw_word");
        tick(1'b1, 5'd13, 32'h1234_5678, 1'b0, 1'b0, "rstw_word");
        idle_in();
        tick(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, "final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
